// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Owns the fetch PC, issues word requests to
//   instruction memory (request/grant, in-order responses), buffers returned
//   words with their addresses in a DEPTH-entry FIFO and hands them to decode
//   over a valid/ready handshake. Decode feeds back redirects and an
//   instruction-legality verdict; an illegal instruction halts fetch until reset.
//
// Parameters
//   RESET_PC  first fetch address after reset (word aligned)
//   DEPTH     FIFO entries / max outstanding requests (power of two, 2..8)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   o_imem_req/addr    fetch request and word address
//   i_imem_gnt         request accepted this cycle
//   i_imem_rvalid/rdata  in-order response word
//   o_instr/o_pc       head instruction and its address (instr=0 when invalid)
//   o_instr_valid      head entry valid
//   i_instr_ready      decode consumes head this cycle
//   i_redirect/_pc     taken branch/jump target
//   i_insn_vld         decode verdict on the current head instruction
//   o_halted           sticky illegal-instruction halt
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_insn_vld,
  output logic        o_halted
);

  localparam int AW = $clog2(DEPTH);
  // one spare bit so count+live and live+stale sums never overflow
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t          r_state, w_state_nx;

  logic [31:0]     r_fpc;
  logic [CW-1:0]   r_count, r_live, r_stale;
  logic [CW-1:0]   w_count_nx, w_live_nx, w_stale_nx;

  // instruction FIFO: {pc, word}
  logic [31:0]     r_fq_pc   [DEPTH];
  logic [31:0]     r_fq_word [DEPTH];
  logic [AW-1:0]   r_fq_wr, r_fq_rd;

  // address of every outstanding request (live and stale), in issue order
  logic [31:0]     r_aq [DEPTH];
  logic [AW-1:0]   r_aq_wr, r_aq_rd;

  logic            w_run, w_pop, w_illegal, w_redir, w_flush;
  logic            w_credit, w_gnt;
  logic            w_rsp_stale, w_rsp_live, w_rsp, w_push;
  logic [CW-1:0]   w_cnt_eff;
  logic            w_unused;

  // address LSBs of a redirect target are dropped
  assign w_unused = ^i_redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign w_run     = (r_state == S_RUN);
  assign w_pop     = o_instr_valid & i_instr_ready;
  // illegal wins over a concurrent redirect
  assign w_illegal = w_run & w_pop & ~i_insn_vld;
  assign w_redir   = w_run & i_redirect & ~w_illegal;
  assign w_flush   = w_redir | w_illegal;

  // A pop this cycle frees a slot for good, so crediting it early is safe:
  // req can never fall again while waiting for grant. Needed for 1 insn/cycle.
  assign w_cnt_eff = r_count - CW'(w_pop);
  assign w_credit  = ((w_cnt_eff + r_live) < DEPTH_C) &&
                     ((r_live + r_stale) < DEPTH_C);

  // gated by rst_n so the request is low throughout reset and rises the
  // first cycle after release
  assign o_imem_req  = rst_n & w_run & ~i_redirect & ~w_illegal & w_credit;
  assign o_imem_addr = r_fpc;
  assign w_gnt       = o_imem_req & i_imem_gnt;

  // stale responses are always the oldest outstanding ones
  assign w_rsp_stale = i_imem_rvalid & (r_stale != '0);
  assign w_rsp_live  = i_imem_rvalid & (r_stale == '0) & (r_live != '0);
  assign w_rsp       = w_rsp_stale | w_rsp_live;
  // a live word arriving with a flush or in HALT is dropped
  assign w_push      = w_rsp_live & w_run & ~w_flush;

  // ---------------------------------------------------------------------------
  // Counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_live_nx  = r_live + CW'(w_gnt) - CW'(w_rsp_live);
    w_stale_nx = r_stale - CW'(w_rsp_stale);
    if (w_redir) begin
      // everything still in flight now belongs to the old path
      w_stale_nx = w_stale_nx + w_live_nx;
      w_live_nx  = '0;
    end
    if (w_flush) w_count_nx = '0;
    else         w_count_nx = r_count + CW'(w_push) - CW'(w_pop);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    if (w_illegal) w_state_nx = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nx;
  end

  // ---------------------------------------------------------------------------
  // Fetch PC and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc   <= RESET_PC;
      r_count <= '0;
      r_live  <= '0;
      r_stale <= '0;
    end else begin
      r_count <= w_count_nx;
      r_live  <= w_live_nx;
      r_stale <= w_stale_nx;
      if (w_redir)    r_fpc <= {i_redirect_pc[31:2], 2'b00};
      else if (w_gnt) r_fpc <= r_fpc + 32'd4;  // wraps mod 2^32
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding-request address queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_aq[i] <= '0;
      r_aq_wr <= '0;
      r_aq_rd <= '0;
    end else begin
      if (w_gnt) begin
        r_aq[r_aq_wr] <= r_fpc;
        r_aq_wr       <= r_aq_wr + AW'(1);
      end
      if (w_rsp) r_aq_rd <= r_aq_rd + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fq_pc[i]   <= RESET_PC;
        r_fq_word[i] <= '0;
      end
      r_fq_wr <= '0;
      r_fq_rd <= '0;
    end else if (w_flush) begin
      r_fq_wr <= '0;
      r_fq_rd <= '0;
    end else begin
      if (w_push) begin
        r_fq_pc[r_fq_wr]   <= r_aq[r_aq_rd];
        r_fq_word[r_fq_wr] <= i_imem_rdata;
        r_fq_wr            <= r_fq_wr + AW'(1);
      end
      if (w_pop) r_fq_rd <= r_fq_rd + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side outputs
  // ---------------------------------------------------------------------------
  assign o_instr_valid = (r_count != '0);
  assign o_pc          = r_fq_pc[r_fq_rd];
  assign o_instr       = o_instr_valid ? r_fq_word[r_fq_rd] : 32'h0;
  assign o_halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc, redirect_pc;
  logic        instr_valid, instr_ready, redirect, insn_vld, halted;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .o_instr(instr), .o_pc(pc), .o_instr_valid(instr_valid),
    .i_instr_ready(instr_ready), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .i_insn_vld(insn_vld), .o_halted(halted));

  always #5 clk = ~clk;

  // memory model: outstanding requests with the cycle their word is due
  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
  mreq_t mq[$];

  int          n_cmp = 0, n_err = 0, n_hs = 0;
  int unsigned cyc = 0;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;
  // reference: next address to fetch, next address decode must see
  logic [31:0] exp_fpc, exp_pc, pend_addr;
  logic        m_halted, pend;

  function automatic logic [31:0] wordf(input logic [31:0] a);
    return a ^ 32'h5A3C_0000;
  endfunction

  // one clock cycle: memory drives gnt/rvalid, scoreboard checks, edge
  task automatic step();
    logic  hs, ill;
    mreq_t r;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = wordf(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    #1;
    hs  = instr_valid & instr_ready;
    ill = hs & ~insn_vld & ~m_halted;
    n_cmp++;
    if (halted !== m_halted) begin n_err++; $display("FAIL halted: got %b want %b cyc %0d", halted, m_halted, cyc); end
    if (m_halted) begin
      n_cmp++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_quiet: req %b valid %b want 0 0", imem_req, instr_valid); end
    end
    if (pend && !redirect && !ill) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin n_err++; $display("FAIL req_hold: req %b addr %h want 1 %h", imem_req, imem_addr, pend_addr); end
    end
    if (imem_req) begin
      n_cmp++;
      if (imem_addr !== exp_fpc) begin n_err++; $display("FAIL imem_addr: got %h want %h cyc %0d", imem_addr, exp_fpc, cyc); end
    end
    if (instr_valid) begin
      n_cmp++;
      if (pc !== exp_pc || instr !== wordf(exp_pc)) begin n_err++; $display("FAIL head: pc %h instr %h want %h %h cyc %0d", pc, instr, exp_pc, wordf(exp_pc), cyc); end
    end else begin
      n_cmp++;
      if (instr !== 32'h0) begin n_err++; $display("FAIL instr_zero: got %h want 0", instr); end
    end
    n_cmp++;
    if (mq.size() > DEPTH) begin n_err++; $display("FAIL outstanding: got %0d want <= %0d", mq.size(), DEPTH); end
    if (ill) begin
      n_cmp++;
      if (imem_req !== 1'b0) begin n_err++; $display("FAIL illegal_req: got %b want 0", imem_req); end
      m_halted = 1'b1;
    end else if (redirect && !m_halted) begin
      n_cmp++;
      if (imem_req !== 1'b0) begin n_err++; $display("FAIL redirect_req: got %b want 0", imem_req); end
      exp_fpc = {redirect_pc[31:2], 2'b00};
      exp_pc  = exp_fpc;
    end else if (hs) exp_pc = exp_pc + 32'd4;
    if (hs) n_hs++;
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr; r.due = cyc + $urandom_range(lat_min, lat_max);
      mq.push_back(r);
      exp_fpc = exp_fpc + 32'd4;
    end
    pend      = imem_req && !imem_gnt;
    pend_addr = imem_addr;
    if (imem_rvalid) void'(mq.pop_front());
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    redirect = 1'b0; insn_vld = 1'b1; instr_ready = 1'b1;
    mq.delete(); m_halted = 1'b0; pend = 1'b0;
    exp_fpc = RESET_PC; exp_pc = RESET_PC;
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    do_reset();
    repeat (6) step();
    // reset mid-transfer
    rst_n = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_cmp++; if (pc !== RESET_PC) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc, RESET_PC); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", halted); end
    do_reset();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL first_req: req %b addr %h want 1 %h", imem_req, imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    int cnt = 0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    while (!instr_valid && cnt < 20) begin step(); cnt++; end
    n_cmp++; if (cnt != 2) begin n_err++; $display("FAIL first_latency: got %0d want 2", cnt); end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (instr_valid !== 1'b1) begin n_err++; $display("FAIL throughput: valid %b want 1 at beat %0d", instr_valid, i); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    instr_ready = 1'b0;
    repeat (10) step();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req: got %b want 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", instr_valid); end
    n_cmp++; if (mq.size() != 0) begin n_err++; $display("FAIL bp_outstanding: got %0d want 0", mq.size()); end
    instr_ready = 1'b1;
    hs0 = n_hs;
    repeat (12) step();
    n_cmp++; if (n_hs - hs0 < 10) begin n_err++; $display("FAIL bp_resume: got %0d handshakes want >= 10", n_hs - hs0); end
  endtask

  task automatic test_redirect_latency();
    gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready = 1'b1;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0; #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: valid %b want 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_req: req %b addr %h want 1 00000100", imem_req, imem_addr); end
    step(); step();
    n_cmp++; if (instr_valid !== 1'b1 || pc !== 32'h100) begin n_err++; $display("FAIL redir_latency: valid %b pc %h want 1 00000100", instr_valid, pc); end
  endtask

  task automatic test_redirect_stale();
    int  cnt = 0;
    logic found = 1'b0;
    gnt_pct = 100; lat_min = 3; lat_max = 3; instr_ready = 1'b1;
    repeat (6) step();
    while (!found && cnt < 30) begin
      if (mq.size() >= 2 && mq[0].due <= cyc) found = 1'b1;
      else begin step(); cnt++; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL stale_setup: outstanding %0d want 2", mq.size()); end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    cnt = 0;
    while (!instr_valid && cnt < 20) begin step(); cnt++; end
    n_cmp++; if (instr_valid !== 1'b1 || pc !== 32'h100) begin n_err++; $display("FAIL stale_drop: valid %b pc %h want 1 00000100", instr_valid, pc); end
    repeat (10) step();
  endtask

  task automatic test_wrap();
    logic seen_top = 1'b0, seen_zero = 1'b0;
    gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid && pc == 32'hFFFF_FFFC) seen_top = 1'b1;
      else if (seen_top && instr_valid && pc == 32'h0) seen_zero = 1'b1;
      step();
    end
    n_cmp++; if (!(seen_top && seen_zero)) begin n_err++; $display("FAIL wrap: top %b zero %b want 1 1", seen_top, seen_zero); end
  endtask

  task automatic test_illegal();
    int cnt = 0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    while (!(instr_valid && pc == 32'h8) && cnt < 20) begin step(); cnt++; end
    n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL ill_setup: pc %h want 00000008", pc); end
    insn_vld = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    insn_vld = 1'b1; redirect = 1'b0;
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL ill_halt: got %b want 1", halted); end
    for (int i = 0; i < 12; i++) begin
      instr_ready = $urandom_range(0, 1);
      redirect    = (i == 4);
      step();
    end
    redirect = 1'b0; instr_ready = 1'b1;
    n_cmp++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL ill_sticky: halted %b valid %b want 1 0", halted, instr_valid); end
    do_reset();
    n_cmp++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL ill_restart: halted %b req %b addr %h", halted, imem_req, imem_addr); end
    cnt = 0;
    while (!instr_valid && cnt < 20) begin step(); cnt++; end
    n_cmp++; if (instr_valid !== 1'b1 || pc !== RESET_PC) begin n_err++; $display("FAIL ill_refetch: valid %b pc %h want 1 %h", instr_valid, pc, RESET_PC); end
  endtask

  task automatic test_random();
    int hs0;
    do_reset();
    hs0 = n_hs;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = $urandom_range(30, 100);
        lat_min = 1; lat_max = $urandom_range(1, 4);
      end
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect = 1'b0;
    n_cmp++; if (n_hs - hs0 < 50) begin n_err++; $display("FAIL random_progress: got %0d handshakes want >= 50", n_hs - hs0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; insn_vld = 1'b1;
    m_halted = 1'b0; pend = 1'b0; pend_addr = '0;
    exp_fpc = RESET_PC; exp_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_stale();
    test_wrap();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
